// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-8 demultiplexer.
// Channel count and select width live here; data width stays a module parameter.
package demux_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef logic [SEL_W-1:0] ch_idx_t;

   // Decode a channel index into a one-hot channel mask.
   function automatic logic [NUM_CH-1:0] sel_onehot(input ch_idx_t sel);
      logic [NUM_CH-1:0] mask;
      mask = {{(NUM_CH-1){1'b0}}, 1'b1};
      return mask << sel;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// A load always wins over a drain, so load+drain in one cycle keeps the slot full.
module demux_slot
   import demux_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] data_in,
   input  logic         ready_out,
   output logic [W-1:0] data,
   output logic         valid
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;
   logic         valid_q;
   logic         valid_d;

   // Next-state: load captures a new word, otherwise a transfer empties the slot.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = data_in;
         valid_d = 1'b1;
      end else if (valid_q && ready_out) begin
         data_d  = data_q;
         valid_d = 1'b0;
      end else begin
         data_d  = data_q;
         valid_d = valid_q;
      end
   end

   // Slot state register; data is kept after a drain and only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= {W{1'b0}};
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/demux_1_8_reg.sv
// Registered 1-to-8 demultiplexer with valid/ready on the input and per channel.
// Only the selected channel can stall the producer; other full channels never do.
module demux_1_8_reg
   import demux_pkg::*;
#(
   parameter int W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SEL_W-1:0]  s,
   input  logic [W-1:0]      d,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [W-1:0]      y0,
   output logic [W-1:0]      y1,
   output logic [W-1:0]      y2,
   output logic [W-1:0]      y3,
   output logic [W-1:0]      y4,
   output logic [W-1:0]      y5,
   output logic [W-1:0]      y6,
   output logic [W-1:0]      y7,
   output logic [NUM_CH-1:0] y_valid,
   input  logic [NUM_CH-1:0] y_ready,
   output logic              busy
);

   logic [NUM_CH-1:0] load_s;
   logic              acc_s;
   logic [W-1:0]      y_arr [NUM_CH];

   assign in_ready = rst_n & (~y_valid[s] | y_ready[s]);
   assign acc_s    = in_valid & in_ready;

   // Route an accepted word to exactly the selected slot.
   always_comb begin
      load_s = {NUM_CH{1'b0}};
      if (acc_s) begin
         load_s = sel_onehot(ch_idx_t'(s));
      end else begin
         load_s = {NUM_CH{1'b0}};
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(.W(W)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load_s[k]),
         .data_in   (d),
         .ready_out (y_ready[k]),
         .data      (y_arr[k]),
         .valid     (y_valid[k])
      );
   end

   assign y0   = y_arr[0];
   assign y1   = y_arr[1];
   assign y2   = y_arr[2];
   assign y3   = y_arr[3];
   assign y4   = y_arr[4];
   assign y5   = y_arr[5];
   assign y6   = y_arr[6];
   assign y7   = y_arr[7];
   assign busy = |y_valid;

endmodule

// File: tb/tb_demux_1_8_reg.sv
// Self-checking bench for demux_1_8_reg: directed scenarios then random traffic,
// compared against a per-channel occupancy model kept in the bench.
module tb_demux_1_8_reg;

   logic       clk;
   logic       rst_n;
   logic [2:0] s;
   logic [2:0] d;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic [7:0] y_valid;
   logic [7:0] y_ready;
   logic       busy;

   demux_1_8_reg #(.W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (s),
      .d        (d),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y0       (y0),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .y4       (y4),
      .y5       (y5),
      .y6       (y6),
      .y7       (y7),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [2:0] yv [8];
   assign yv[0] = y0;
   assign yv[1] = y1;
   assign yv[2] = y2;
   assign yv[3] = y3;
   assign yv[4] = y4;
   assign yv[5] = y5;
   assign yv[6] = y6;
   assign yv[7] = y7;

   // Reference model: which channels hold a word, and the last word each received.
   logic [7:0] mv;
   logic [2:0] my [8];

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("y_valid", y_valid, mv);
      chk("busy", {7'd0, busy}, {7'd0, (mv != 8'h00)});
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("y%0d", k), {5'd0, yv[k]}, {5'd0, my[k]});
      end
   endtask

   task automatic model_reset();
      mv = 8'h00;
      for (int k = 0; k < 8; k++) my[k] = 3'd0;
   endtask

   // One clock of traffic: drive, check in_ready, clock, advance model, check outputs.
   task automatic step(input logic iv, input logic [2:0] ss, input logic [2:0] dd,
                       input logic [7:0] yr);
      logic exp_rdy;
      logic acc;
      @(negedge clk);
      in_valid = iv;
      s        = ss;
      d        = dd;
      y_ready  = yr;
      #1;
      exp_rdy = rst_n && (!mv[ss] || yr[ss]);
      chk("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
      acc = iv && exp_rdy;
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         if (mv[k] && yr[k]) mv[k] = 1'b0;
      end
      if (acc) begin
         mv[ss] = 1'b1;
         my[ss] = dd;
      end
      check_all();
   endtask

   initial begin
      model_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      s        = 3'd2;
      d        = 3'd7;
      y_ready  = 8'h00;
      #2;
      chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
      check_all();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Sweep every channel with full drain: one-hot occupancy, no stalls.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 3'(k), 3'(k), 8'hFF);
         chk("sweep_yk", {5'd0, yv[k]}, 8'(k));
      end

      // Backpressure on channel 3.
      step(1'b0, 3'd0, 3'd0, 8'hFF);
      step(1'b1, 3'd3, 3'b101, 8'h00);
      step(1'b1, 3'd3, 3'b110, 8'h00);
      chk("bp_in_ready", {7'd0, in_ready}, 8'h00);
      chk("bp_y3_hold", {5'd0, y3}, 8'b0000_0101);
      step(1'b1, 3'd3, 3'b110, 8'h00);
      step(1'b1, 3'd3, 3'b110, 8'h08);
      chk("bp_y3_new", {5'd0, y3}, 8'b0000_0110);

      // Cross-channel: stalled channel 3 must not block channel 5.
      step(1'b0, 3'd0, 3'd0, 8'hFF);
      step(1'b1, 3'd3, 3'b101, 8'h00);
      step(1'b1, 3'd5, 3'b011, 8'h00);
      chk("cross_valid", y_valid, 8'b0010_1000);
      chk("cross_y5", {5'd0, y5}, 8'b0000_0011);
      chk("cross_y3", {5'd0, y3}, 8'b0000_0101);

      // Same-cycle load and drain on channel 3.
      step(1'b1, 3'd3, 3'b010, 8'h08);
      chk("ld_dr_y3", {5'd0, y3}, 8'b0000_0010);
      chk("ld_dr_v3", {7'd0, y_valid[3]}, 8'h01);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 8'($urandom));
      end

      // Fill all channels, then reset asynchronously between edges.
      step(1'b0, 3'd0, 3'd0, 8'hFF);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 3'(k), 3'(7 - k), 8'h00);
      end
      chk("full_valid", y_valid, 8'hFF);
      @(negedge clk);
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_valid", y_valid, 8'h00);
      chk("arst_in_ready", {7'd0, in_ready}, 8'h00);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 3'd4, 3'd7, 8'hFF);
      chk("resume_y4", {5'd0, y4}, 8'h07);
      step(1'b1, 3'd1, 3'd6, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
